// File: rtl/stack_cpu_driver_pkg.sv
// stack_cpu_driver_pkg: opcodes, command layout, FSM states and decode helpers for the stack_cpu driver.
package stack_cpu_driver_pkg;
  typedef enum logic [3:0] {
    OP_NOOP = 4'd0,
    OP_PUSH = 4'd1,
    OP_POP  = 4'd2,
    OP_OUTL = 4'd3,
    OP_OUTH = 4'd4,
    OP_SWAP = 4'd5,
    OP_PEEK = 4'd6,
    OP_DUP  = 4'd7,
    OP_AND  = 4'd8
  } op_t;
  typedef enum logic [1:0] {S_CRST, S_IDLE, S_EXEC} state_t;
  typedef struct packed {
    logic [3:0] op;
    logic [3:0] arg;
  } cmd_t;
  localparam logic [1:0] MODE_CPU = 2'b00;
  function automatic logic [1:0] instr_len(input logic [3:0] op);
    return (op inside {OP_PUSH, OP_POP, OP_SWAP, OP_PEEK, OP_DUP, OP_AND}) ? 2'd3 : 2'd2;
  endfunction
  function automatic logic is_readback(input logic [3:0] op);
    return op == OP_OUTL || op == OP_OUTH;
  endfunction
endpackage

// File: rtl/stack_cpu_driver_cmd_fifo.sv
// cmd_fifo: synchronous FIFO of 8-bit {op,arg} commands with full/empty flags.
module cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign rdata = mem[rp[AW-1:0]];
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= wdata;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/stack_cpu_driver.sv
// stack_cpu_driver: drives stack_cpu io_in (clock, reset, nibbles, mode) from a command FIFO and reads back OUTL/OUTH results.
module stack_cpu_driver
  import stack_cpu_driver_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int RESET_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [3:0] cmd_arg,
  input  logic [1:0] disp_mode,
  output logic [7:0] cpu_io_in,
  input  logic [7:0] cpu_io_out,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy
);
  localparam int RCW = $clog2(RESET_CYCLES + 1);
  localparam logic [RCW-1:0] RC_LAST = RCW'(RESET_CYCLES);
  state_t state;
  logic phase, cpu_rst, full, empty, pop, start, capture, last;
  logic [3:0] nib;
  logic [1:0] mode, idx;
  logic [RCW-1:0] rcnt;
  cmd_t cur, head, nxt;
  cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(cmd_valid && cmd_ready),
    .pop(pop),
    .wdata({cmd_op, cmd_arg}),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
  assign cpu_io_in = {mode, nib, cpu_rst, phase};
  assign cmd_ready = state != S_CRST && !full;
  assign busy = !(state == S_IDLE && empty);
  // phase=1 means this clk edge drops the CPU clock: the only edge where bits [7:1] may change
  assign last = idx == instr_len(cur.op) - 2'd1;
  assign start = phase && (state == S_CRST ? rcnt == RC_LAST : last);
  assign pop = start && !empty;
  assign nxt = pop ? head : '0;
  assign capture = phase && is_readback(cur.op) && idx == 2'd1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_CRST;
      phase    <= 1'b0;
      cpu_rst  <= 1'b1;
      nib      <= '0;
      mode     <= MODE_CPU;
      rcnt     <= '0;
      idx      <= '0;
      cur      <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      phase    <= ~phase;
      rd_valid <= capture;
      if (capture) rd_data <= cpu_io_out;
      if (state == S_CRST && !phase && rcnt != RC_LAST) rcnt <= rcnt + 1'b1;
      if (start) begin
        state   <= pop ? S_EXEC : S_IDLE;
        cpu_rst <= 1'b0;
        cur     <= nxt;
        idx     <= '0;
        nib     <= nxt.op;
        mode    <= is_readback(nxt.op) ? MODE_CPU : disp_mode;
      end else if (phase && state != S_CRST) begin
        idx  <= idx + 2'd1;
        nib  <= (cur.op == OP_PUSH && idx == 2'd1) ? cur.arg : 4'd0;
        mode <= is_readback(cur.op) ? MODE_CPU : disp_mode;
      end
    end
  end
endmodule

// File: tb/tb_stack_cpu_driver.sv
// tb_stack_cpu_driver: directed and random checks of the driver against a behavioural stack_cpu model.
module tb_stack_cpu_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [3:0] cmd_op = 4'd0;
  logic [3:0] cmd_arg = 4'd0;
  logic [1:0] disp_mode = 2'b01;
  logic [7:0] cpu_io_in, cpu_io_out, rd_data;
  logic rd_valid, busy;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  stack_cpu_driver #(.FIFO_DEPTH(4), .RESET_CYCLES(2)) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_arg(cmd_arg),
    .disp_mode(disp_mode),
    .cpu_io_in(cpu_io_in),
    .cpu_io_out(cpu_io_out),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .busy(busy)
  );
  // Behavioural stack_cpu plus protocol monitor
  logic [7:0] m_out = 8'h00;
  logic [7:0] prev = 8'h02;
  logic [3:0] stk [8];
  logic [3:0] m_op = 4'd0;
  logic [3:0] m_arg = 4'd0;
  int m_idx = 0;
  int m_len = 2;
  int mon_err = 0;
  int rd_cnt = 0;
  int rd_n = 0;
  int wr_n = 0;
  int nib_n = 0;
  logic [3:0] exp_op [1024];
  logic [3:0] exp_arg [1024];
  logic [3:0] nib_log [8192];
  assign cpu_io_out = m_out;
  task automatic spush(input logic [3:0] v);
    for (int i = 7; i > 0; i--) stk[i] = stk[i-1];
    stk[0] = v;
  endtask
  task automatic spop();
    for (int i = 0; i < 7; i++) stk[i] = stk[i+1];
    stk[7] = 4'd0;
  endtask
  task automatic cpu_edge();
    logic [3:0] n, t, en;
    logic [1:0] em;
    n = cpu_io_in[5:2];
    if (cpu_io_in[1]) begin
      for (int i = 0; i < 8; i++) stk[i] = 4'd0;
      m_out = 8'h00;
      m_idx = 0;
    end else begin
      nib_log[nib_n % 8192] = n;
      nib_n++;
      if (m_idx == 0) begin
        m_op = n;
        m_len = (n inside {4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8}) ? 3 : 2;
        m_arg = 4'd0;
        if (n != 4'd0) begin
          if (rd_n >= wr_n || n != exp_op[rd_n % 1024]) begin
            mon_err++;
            $display("[TB] unexpected fetch %h at %0t", n, $time);
          end else m_arg = exp_arg[rd_n % 1024];
          if (rd_n < wr_n) rd_n++;
        end
        m_idx = 1;
      end else begin
        en = (m_op == 4'd1 && m_idx == 2) ? m_arg : 4'd0;
        if (n != en) begin
          mon_err++;
          $display("[TB] nibble %h at edge %0d of op %h, expected %h", n, m_idx, m_op, en);
        end
        if (m_idx == m_len - 1) begin
          case (m_op)
            4'd1: spush(n);
            4'd2: spop();
            4'd3: begin m_out[3:0] = stk[0]; spop(); end
            4'd4: begin m_out[7:4] = stk[0]; spop(); end
            4'd5: begin t = stk[0]; stk[0] = stk[1]; stk[1] = t; end
            4'd6: spush(stk[1]);
            4'd7: spush(stk[0]);
            4'd8: begin t = stk[0] & stk[1]; spop(); stk[0] = t; end
            default: ;
          endcase
          m_idx = 0;
        end else m_idx++;
      end
      em = (m_op == 4'd3 || m_op == 4'd4) ? 2'b00 : disp_mode;
      if (cpu_io_in[7:6] != em) begin
        mon_err++;
        $display("[TB] mode %b on op %h, expected %b", cpu_io_in[7:6], m_op, em);
      end
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (rd_valid) rd_cnt++;
    if (rst) begin
      rd_n = wr_n;
      m_idx = 0;
    end else begin
      if (cpu_io_in[0] == prev[0] || (cpu_io_in[7:1] != prev[7:1] && !(prev[0] && !cpu_io_in[0]))) begin
        mon_err++;
        $display("[TB] timing violation at %0t: %h -> %h", $time, prev, cpu_io_in);
      end
      if (rd_valid && rd_data !== m_out) begin
        mon_err++;
        $display("[TB] readback %h, model output %h", rd_data, m_out);
      end
      if (cpu_io_in[0] && !prev[0]) cpu_edge();
    end
    prev = cpu_io_in;
  end
  // Bench-side command issue and readback collection
  logic [7:0] rdq [8];
  int rdn;
  task automatic send(input logic [3:0] op, input logic [3:0] arg);
    int t;
    logic acc;
    t = 0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_arg = arg;
    do begin
      acc = cmd_ready;
      @(negedge clk);
      t++;
    end while (!acc && t < 400);
    if (acc) begin
      exp_op[wr_n % 1024] = op;
      exp_arg[wr_n % 1024] = arg;
      wr_n++;
    end else begin
      tests++;
      fails++;
      $display("[TB] FAIL send_timeout op=%h: cmd_ready got 0, expected 1", op);
    end
    cmd_valid = 1'b0;
  endtask
  task automatic run_idle();
    int i;
    rdn = 0;
    for (i = 0; i < 3000; i++) begin
      if (rd_valid) begin
        if (rdn < 8) rdq[rdn] = rd_data;
        rdn++;
      end
      if (!busy) break;
      @(negedge clk);
    end
    if (i == 3000) begin
      tests++;
      fails++;
      $display("[TB] FAIL idle_timeout: busy got 1, expected 0");
    end
    repeat (8) begin
      @(negedge clk);
      if (rd_valid) begin
        if (rdn < 8) rdq[rdn] = rd_data;
        rdn++;
      end
    end
  endtask
  task automatic do_reset();
    int i;
    rst = 1'b1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (i = 0; i < 50 && cpu_io_in[1]; i++) @(negedge clk);
    if (i == 50) begin
      tests++;
      fails++;
      $display("[TB] FAIL reset_timeout: cpu rst got 1, expected 0");
    end
  endtask
  task automatic test_reset();
    int cnt;
    logic p0;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (cpu_io_in !== 8'h02 || cmd_ready !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 8'h00 || busy !== 1'b1) begin
        fails++;
        $display("[TB] FAIL reset_state: io=%h ready=%b rdv=%b rdd=%h busy=%b, expected 02 0 0 00 1",
                 cpu_io_in, cmd_ready, rd_valid, rd_data, busy);
      end
    end
    rst = 1'b0;
    cnt = 0;
    p0 = cpu_io_in[0];
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cpu_io_in[0] && !p0 && cpu_io_in[1]) cnt++;
      p0 = cpu_io_in[0];
      if (!cpu_io_in[1]) break;
    end
    tests++;
    if (cnt !== 2) begin fails++; $display("[TB] FAIL reset_edges: got %0d, expected 2", cnt); end
    tests++;
    if (cpu_io_in[1] !== 1'b0) begin fails++; $display("[TB] FAIL reset_release: rst bit got %b, expected 0", cpu_io_in[1]); end
    tests++;
    if (cmd_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b, expected 1", cmd_ready); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    tests++;
    if (cpu_io_in[7:2] !== {2'b01, 4'd0}) begin fails++; $display("[TB] FAIL reset_noop: got %h, expected 01_0", cpu_io_in[7:2]); end
  endtask
  task automatic test_push_outl();
    logic [3:0] en [5];
    int s, k;
    en[0] = 4'd1; en[1] = 4'd0; en[2] = 4'd5; en[3] = 4'd3; en[4] = 4'd0;
    s = nib_n;
    send(4'd1, 4'd5);
    send(4'd3, 4'd0);
    run_idle();
    tests++;
    if (rdn !== 1) begin fails++; $display("[TB] FAIL push_outl_count: got %0d, expected 1", rdn); end
    tests++;
    if (rdq[0] !== 8'h05) begin fails++; $display("[TB] FAIL push_outl_data: got %h, expected 05", rdq[0]); end
    k = s;
    while (k < nib_n && nib_log[k % 8192] == 4'd0) k++;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (nib_log[(k + i) % 8192] !== en[i]) begin
        fails++;
        $display("[TB] FAIL push_outl_nibble%0d: got %h, expected %h", i, nib_log[(k + i) % 8192], en[i]);
      end
    end
  endtask
  task automatic test_swap_outh();
    do_reset();
    send(4'd1, 4'd3);
    send(4'd1, 4'd9);
    send(4'd5, 4'd0);
    send(4'd4, 4'd0);
    send(4'd3, 4'd0);
    run_idle();
    tests++;
    if (rdn !== 2) begin fails++; $display("[TB] FAIL swap_count: got %0d, expected 2", rdn); end
    tests++;
    if (rdq[0] !== 8'h30) begin fails++; $display("[TB] FAIL swap_outh: got %h, expected 30", rdq[0]); end
    tests++;
    if (rdq[1] !== 8'h39) begin fails++; $display("[TB] FAIL swap_outl: got %h, expected 39", rdq[1]); end
  endtask
  task automatic test_back_to_back();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send(4'd1, 4'd1);
    send(4'd1, 4'd2);
    send(4'd3, 4'd0);
    send(4'd4, 4'd0);
    send(4'd3, 4'd0);
    tests++;
    if (cmd_ready !== 1'b0) begin fails++; $display("[TB] FAIL b2b_full: cmd_ready got %b, expected 0", cmd_ready); end
    run_idle();
    tests++;
    if (rdn !== 3) begin fails++; $display("[TB] FAIL b2b_count: got %0d, expected 3", rdn); end
    tests++;
    if (rdq[0] !== 8'h02) begin fails++; $display("[TB] FAIL b2b_rd0: got %h, expected 02", rdq[0]); end
    tests++;
    if (rdq[1] !== 8'h12) begin fails++; $display("[TB] FAIL b2b_rd1: got %h, expected 12", rdq[1]); end
    tests++;
    if (rdq[2] !== 8'h10) begin fails++; $display("[TB] FAIL b2b_rd2: got %h, expected 10", rdq[2]); end
  endtask
  task automatic test_random();
    int outs, rc0;
    logic [3:0] op;
    rst = 1'b1;
    disp_mode = 2'b10;
    do_reset();
    outs = 0;
    rc0 = rd_cnt;
    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom_range(1, 15));
      if (op == 4'd3 || op == 4'd4) outs++;
      send(op, 4'($urandom_range(0, 15)));
    end
    run_idle();
    tests++;
    if (rd_cnt - rc0 !== outs) begin fails++; $display("[TB] FAIL random_reads: got %0d, expected %0d", rd_cnt - rc0, outs); end
    tests++;
    if (rd_n !== wr_n) begin fails++; $display("[TB] FAIL random_fetched: got %0d, expected %0d", rd_n, wr_n); end
    tests++;
    if (mon_err !== 0) begin fails++; $display("[TB] FAIL monitor_errors: got %0d, expected 0", mon_err); end
  endtask
  task automatic test_async_reset();
    int i, rc0;
    send(4'd1, 4'd2);
    send(4'd3, 4'd0);
    for (i = 0; i < 100 && !(m_op == 4'd1 && m_idx == 2 && cpu_io_in[0]); i++) @(negedge clk);
    tests++;
    if (i == 100) begin fails++; $display("[TB] FAIL arst_trigger: PUSH E0 not seen, expected within 100 clk"); end
    rc0 = rd_cnt;
    rst = 1'b1;
    #1;
    tests++;
    if (cpu_io_in !== 8'h02) begin fails++; $display("[TB] FAIL arst_io: got %h, expected 02", cpu_io_in); end
    tests++;
    if (cmd_ready !== 1'b0 || rd_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL arst_flags: ready=%b rdv=%b, expected 0 0", cmd_ready, rd_valid);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (i = 0; i < 50 && cpu_io_in[1]; i++) @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("[TB] FAIL arst_flush: busy got %b, expected 0", busy); end
    repeat (6) @(negedge clk);
    tests++;
    if (rd_cnt !== rc0) begin fails++; $display("[TB] FAIL arst_no_rd: got %0d pulses, expected 0", rd_cnt - rc0); end
    send(4'd1, 4'd7);
    send(4'd3, 4'd0);
    run_idle();
    tests++;
    if (rdn !== 1 || rdq[0] !== 8'h07) begin
      fails++;
      $display("[TB] FAIL arst_rerun: got %0d reads data %h, expected 1 reads data 07", rdn, rdq[0]);
    end
  endtask
  initial begin
    test_reset();
    test_push_outl();
    test_swap_outh();
    test_back_to_back();
    test_random();
    test_async_reset();
    tests++;
    if (mon_err !== 0) begin fails++; $display("[TB] FAIL monitor_final: got %0d, expected 0", mon_err); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
